// File: rtl/dcache_mem_ctrl.sv
// Data-cache miss controller.
// Buffers writebacks, write-miss stores and read-miss loads in a request FIFO,
// issues the FIFO head to memory, tracks outstanding loads in MSHRs and turns
// tagged memory responses into dcache fills and LSQ load completions.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   except                  squash every pending and outstanding load
//   wb_*_in                 dirty-line writeback (always DOUBLE)
//   wr_*_in                 write-miss store
//   rd_*_in                 read-miss load with its LSQ grant
//   ready                   at least three free FIFO entries
//   mem2proc_*              memory response/tag/data
//   Dmem_*                  request presented to memory
//   mem_feedback, mem_data  completed-load grant and extracted load data
//   mem_wr_*                dcache line fill
module dcache_mem_ctrl #(
    parameter int unsigned LSQSZ     = 8,
    parameter int unsigned REQ_DEPTH = 8,
    parameter int unsigned MSHR_NUM  = 4,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              except,
    input  logic              wb_en_in,
    input  logic [ADDR_W-1:0] wb_addr_in,
    input  logic [63:0]       wb_data_in,
    input  logic              wr_en_in,
    input  logic [ADDR_W-1:0] wr_addr_in,
    input  logic [63:0]       wr_data_in,
    input  logic [1:0]        wr_size_in,
    input  logic              rd_en_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic [1:0]        rd_size_in,
    input  logic [LSQSZ-1:0]  rd_gnt_in,
    output logic              ready,
    input  logic [3:0]        mem2proc_response,
    input  logic [63:0]       mem2proc_data,
    input  logic [3:0]        mem2proc_tag,
    output logic [1:0]        Dmem_command,
    output logic [ADDR_W-1:0] Dmem_addr,
    output logic [1:0]        Dmem_size,
    output logic [63:0]       Dmem_data,
    output logic [LSQSZ-1:0]  mem_feedback,
    output logic [31:0]       mem_data,
    output logic              mem_wr_en,
    output logic [4:0]        mem_wr_idx,
    output logic [ADDR_W-9:0] mem_wr_tag,
    output logic [63:0]       mem_wr_data
);

    localparam logic [1:0] BusNone  = 2'd0;
    localparam logic [1:0] BusLoad  = 2'd1;
    localparam logic [1:0] BusStore = 2'd2;

    localparam logic [1:0] SizeByte   = 2'd0;
    localparam logic [1:0] SizeHalf   = 2'd1;
    localparam logic [1:0] SizeDouble = 2'd3;

    localparam int unsigned PtrW  = $clog2(REQ_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BlkW  = ADDR_W - 3;
    localparam int unsigned MIdxW = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

    typedef struct packed {
        logic              is_load;
        logic              squash;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic [63:0]       data;
        logic [LSQSZ-1:0]  gnt;
    } req_t;

    typedef struct packed {
        logic             valid;
        logic             squash;
        logic [3:0]       tag;
        logic [BlkW-1:0]  blk;
        logic [2:0]       off;
        logic [1:0]       size;
        logic [LSQSZ-1:0] gnt;
    } mshr_t;

    req_t  fifo_q [REQ_DEPTH];
    mshr_t mshr_q [MSHR_NUM];

    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q, count_d;

    req_t             head;
    logic             fifo_empty;
    logic             ready_int;
    logic             do_wb, do_wr, do_rd;
    logic [1:0]       n_before_rd, n_enq;
    logic [PtrW-1:0]  wr_slot, rd_slot;
    logic             alloc_found;
    logic [MIdxW-1:0] alloc_idx;
    logic             blk_conflict;
    logic             head_squashed, head_blocked;
    logic             issue, accept, pop;
    logic             comp_hit;
    logic [MIdxW-1:0] comp_idx;
    mshr_t            comp_e;
    logic [63:0]      comp_shift;
    logic             unused_shift_hi;

    assign head       = fifo_q[head_q];
    assign fifo_empty = (count_q == '0);
    assign ready_int  = (CntW'(REQ_DEPTH) - count_q) >= CntW'(3);
    assign ready      = reset | ready_int;

    // Enqueue is all-or-nothing per cycle: with <3 free entries every enable is dropped.
    assign do_wb       = ready_int & wb_en_in;
    assign do_wr       = ready_int & wr_en_in;
    assign do_rd       = ready_int & rd_en_in;
    assign n_before_rd = {1'b0, do_wb} + {1'b0, do_wr};
    assign n_enq       = n_before_rd + {1'b0, do_rd};
    assign wr_slot     = tail_q + PtrW'(do_wb);
    assign rd_slot     = tail_q + PtrW'(n_before_rd);

    always_comb begin
        alloc_found  = 1'b0;
        alloc_idx    = '0;
        comp_hit     = 1'b0;
        comp_idx     = '0;
        blk_conflict = 1'b0;
        // Walk downward so the lowest matching index wins.
        for (int i = MSHR_NUM - 1; i >= 0; i--) begin
            if (!mshr_q[i].valid) begin
                alloc_found = 1'b1;
                alloc_idx   = MIdxW'(i);
            end
            if (mshr_q[i].valid && (mem2proc_tag != 4'd0) && (mshr_q[i].tag == mem2proc_tag)) begin
                comp_hit = 1'b1;
                comp_idx = MIdxW'(i);
            end
            if (mshr_q[i].valid && (mshr_q[i].blk == head.addr[ADDR_W-1:3])) begin
                blk_conflict = 1'b1;
            end
        end
    end

    // A store may not overtake an outstanding load to the same block; a MSHR
    // completing this cycle still counts until it is freed at the edge.
    assign head_squashed = !fifo_empty && head.is_load && head.squash;
    assign head_blocked  = head.is_load ? !alloc_found : blk_conflict;
    assign issue         = !reset && !fifo_empty && !head_squashed && !head_blocked;
    assign accept        = issue && (mem2proc_response != 4'd0);
    assign pop           = accept || (!reset && head_squashed);
    assign count_d       = count_q + CntW'(n_enq) - CntW'(pop);

    always_comb begin
        Dmem_command = BusNone;
        Dmem_addr    = '0;
        Dmem_size    = '0;
        Dmem_data    = '0;
        if (issue) begin
            if (head.is_load) begin
                Dmem_command = BusLoad;
                Dmem_addr    = {head.addr[ADDR_W-1:3], 3'b000};
                Dmem_size    = SizeDouble;
            end else begin
                Dmem_command = BusStore;
                Dmem_addr    = head.addr;
                Dmem_size    = head.size;
                Dmem_data    = head.data;
            end
        end
    end

    assign comp_e          = mshr_q[comp_idx];
    assign comp_shift      = mem2proc_data >> {comp_e.off, 3'b000};
    assign unused_shift_hi = ^comp_shift[63:32];

    always_comb begin
        mem_wr_en    = 1'b0;
        mem_wr_idx   = '0;
        mem_wr_tag   = '0;
        mem_wr_data  = '0;
        mem_feedback = '0;
        mem_data     = '0;
        if (comp_hit && !reset) begin
            mem_wr_en   = 1'b1;
            mem_wr_idx  = comp_e.blk[4:0];
            mem_wr_tag  = comp_e.blk[BlkW-1:5];
            mem_wr_data = mem2proc_data;
            // Squashed loads still fill the cache but report nothing to the LSQ.
            if (!comp_e.squash) begin
                mem_feedback = comp_e.gnt;
                unique case (comp_e.size)
                    SizeByte: mem_data = {24'b0, comp_shift[7:0]};
                    SizeHalf: mem_data = {16'b0, comp_shift[15:0]};
                    default:  mem_data = comp_shift[31:0];
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < MSHR_NUM; i++) begin
                mshr_q[i] <= '0;
            end
        end else begin
            if (except) begin
                for (int i = 0; i < REQ_DEPTH; i++) begin
                    if (fifo_q[i].is_load) fifo_q[i].squash <= 1'b1;
                end
                for (int i = 0; i < MSHR_NUM; i++) begin
                    if (mshr_q[i].valid) mshr_q[i].squash <= 1'b1;
                end
            end

            if (do_wb) begin
                fifo_q[tail_q] <= '{is_load: 1'b0, squash: 1'b0, addr: wb_addr_in,
                                    size: SizeDouble, data: wb_data_in, gnt: '0};
            end
            if (do_wr) begin
                fifo_q[wr_slot] <= '{is_load: 1'b0, squash: 1'b0, addr: wr_addr_in,
                                     size: wr_size_in, data: wr_data_in, gnt: '0};
            end
            if (do_rd) begin
                fifo_q[rd_slot] <= '{is_load: 1'b1, squash: except, addr: rd_addr_in,
                                     size: rd_size_in, data: '0, gnt: rd_gnt_in};
            end

            if (comp_hit) begin
                mshr_q[comp_idx].valid <= 1'b0;
            end
            if (accept && head.is_load) begin
                mshr_q[alloc_idx] <= '{valid: 1'b1, squash: except, tag: mem2proc_response,
                                       blk: head.addr[ADDR_W-1:3], off: head.addr[2:0],
                                       size: head.size, gnt: head.gnt};
            end

            if (pop) head_q <= head_q + PtrW'(1);
            tail_q  <= tail_q + PtrW'(n_enq);
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Self-checking bench for dcache_mem_ctrl: expected memory requests are queued
// as stimulus is enqueued and compared as the DUT issues them; outstanding
// loads are tracked per memory tag to predict fills and LSQ completions.
module tb_dcache_mem_ctrl;

    localparam int unsigned LSQSZ  = 8;
    localparam int unsigned ADDR_W = 16;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;

    logic              clock = 1'b0;
    logic              reset, except;
    logic              wb_en_in, wr_en_in, rd_en_in;
    logic [ADDR_W-1:0] wb_addr_in, wr_addr_in, rd_addr_in;
    logic [63:0]       wb_data_in, wr_data_in;
    logic [1:0]        wr_size_in, rd_size_in;
    logic [LSQSZ-1:0]  rd_gnt_in;
    logic              ready;
    logic [3:0]        mem2proc_response, mem2proc_tag;
    logic [63:0]       mem2proc_data;
    logic [1:0]        Dmem_command, Dmem_size;
    logic [ADDR_W-1:0] Dmem_addr;
    logic [63:0]       Dmem_data;
    logic [LSQSZ-1:0]  mem_feedback;
    logic [31:0]       mem_data;
    logic              mem_wr_en;
    logic [4:0]        mem_wr_idx;
    logic [ADDR_W-9:0] mem_wr_tag;
    logic [63:0]       mem_wr_data;

    always #5 clock = ~clock;

    dcache_mem_ctrl #(
        .LSQSZ(LSQSZ), .REQ_DEPTH(8), .MSHR_NUM(4), .ADDR_W(ADDR_W)
    ) dut (
        .clock(clock), .reset(reset), .except(except),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
        .wr_size_in(wr_size_in),
        .rd_en_in(rd_en_in), .rd_addr_in(rd_addr_in), .rd_size_in(rd_size_in),
        .rd_gnt_in(rd_gnt_in), .ready(ready),
        .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag),
        .Dmem_command(Dmem_command), .Dmem_addr(Dmem_addr), .Dmem_size(Dmem_size),
        .Dmem_data(Dmem_data), .mem_feedback(mem_feedback), .mem_data(mem_data),
        .mem_wr_en(mem_wr_en), .mem_wr_idx(mem_wr_idx), .mem_wr_tag(mem_wr_tag),
        .mem_wr_data(mem_wr_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
        logic        is_load;
        logic        squash;
        logic [15:0] raddr;
        logic [1:0]  rsize;
        logic [7:0]  gnt;
    } exp_t;

    exp_t exp_q[$];

    // Outstanding-load model, indexed by memory tag.
    logic        t_valid [16];
    logic        t_sq    [16];
    logic [15:0] t_addr  [16];
    logic [1:0]  t_size  [16];
    logic [7:0]  t_gnt   [16];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        wb_en_in = 1'b0; wr_en_in = 1'b0; rd_en_in = 1'b0; except = 1'b0;
        mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
    endtask

    task automatic enq_wb(input logic [15:0] a, input logic [63:0] d);
        exp_t e;
        wb_en_in = 1'b1; wb_addr_in = a; wb_data_in = d;
        e = '{cmd: BUS_STORE, addr: a, size: 2'd3, data: d, is_load: 1'b0, squash: 1'b0,
              raddr: a, rsize: 2'd3, gnt: '0};
        exp_q.push_back(e);
    endtask

    task automatic enq_wr(input logic [15:0] a, input logic [63:0] d, input logic [1:0] s);
        exp_t e;
        wr_en_in = 1'b1; wr_addr_in = a; wr_data_in = d; wr_size_in = s;
        e = '{cmd: BUS_STORE, addr: a, size: s, data: d, is_load: 1'b0, squash: 1'b0,
              raddr: a, rsize: s, gnt: '0};
        exp_q.push_back(e);
    endtask

    task automatic enq_rd(input logic [15:0] a, input logic [1:0] s, input logic [7:0] g);
        exp_t e;
        rd_en_in = 1'b1; rd_addr_in = a; rd_size_in = s; rd_gnt_in = g;
        e = '{cmd: BUS_LOAD, addr: {a[15:3], 3'b000}, size: 2'd3, data: '0, is_load: 1'b1,
              squash: 1'b0, raddr: a, rsize: s, gnt: g};
        exp_q.push_back(e);
    endtask

    task automatic do_except();
        except = 1'b1;
        foreach (exp_q[i]) if (exp_q[i].is_load) exp_q[i].squash = 1'b1;
        for (int t = 0; t < 16; t++) if (t_valid[t]) t_sq[t] = 1'b1;
    endtask

    task automatic drop_squashed();
        exp_t keep[$];
        foreach (exp_q[i]) if (!exp_q[i].squash) keep.push_back(exp_q[i]);
        exp_q = keep;
    endtask

    task automatic cmp_head(input string tag, input exp_t e);
        check_eq({tag, ".cmd"},  64'(Dmem_command), 64'(e.cmd));
        check_eq({tag, ".addr"}, 64'(Dmem_addr),    64'(e.addr));
        check_eq({tag, ".size"}, 64'(Dmem_size),    64'(e.size));
        check_eq({tag, ".data"}, Dmem_data,         e.data);
    endtask

    function automatic exp_t front();
        exp_t e;
        if (exp_q.size() == 0) begin
            e = '{cmd: 2'd3, addr: '0, size: '0, data: '0, is_load: 1'b0, squash: 1'b0,
                  raddr: '0, rsize: '0, gnt: '0};
        end else begin
            e = exp_q[0];
        end
        return e;
    endfunction

    // Head presented but not accepted this cycle.
    task automatic hold(input string tag);
        #1;
        cmp_head(tag, front());
    endtask

    task automatic accept(input string tag, input logic [3:0] resp);
        exp_t e;
        mem2proc_response = resp;
        #1;
        e = front();
        cmp_head(tag, e);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (e.is_load) begin
            t_valid[resp] = 1'b1; t_sq[resp] = e.squash; t_addr[resp] = e.raddr;
            t_size[resp] = e.rsize; t_gnt[resp] = e.gnt;
        end
    endtask

    task automatic idle(input string tag);
        #1;
        check_eq({tag, ".cmd"},  64'(Dmem_command), 64'(BUS_NONE));
        check_eq({tag, ".addr"}, 64'(Dmem_addr),    64'd0);
        check_eq({tag, ".data"}, Dmem_data,         64'd0);
    endtask

    task automatic complete(input string tag, input logic [3:0] t, input logic [63:0] d);
        logic [63:0] sh;
        logic [31:0] md;
        logic        we;
        logic [4:0]  idx;
        logic [7:0]  ctag, fb;
        logic [63:0] wd;
        mem2proc_tag = t; mem2proc_data = d;
        #1;
        we = 1'b0; idx = '0; ctag = '0; fb = '0; md = '0; wd = '0;
        if (t != 4'd0 && t_valid[t]) begin
            we = 1'b1; idx = t_addr[t][7:3]; ctag = t_addr[t][15:8]; wd = d;
            if (!t_sq[t]) begin
                fb = t_gnt[t];
                sh = d >> (8 * t_addr[t][2:0]);
                case (t_size[t])
                    2'd0:    md = {24'b0, sh[7:0]};
                    2'd1:    md = {16'b0, sh[15:0]};
                    default: md = sh[31:0];
                endcase
            end
            t_valid[t] = 1'b0;
        end
        check_eq({tag, ".wr_en"}, 64'(mem_wr_en),    64'(we));
        check_eq({tag, ".idx"},   64'(mem_wr_idx),   64'(idx));
        check_eq({tag, ".wtag"},  64'(mem_wr_tag),   64'(ctag));
        check_eq({tag, ".wdata"}, mem_wr_data,       wd);
        check_eq({tag, ".fb"},    64'(mem_feedback), 64'(fb));
        check_eq({tag, ".data"},  64'(mem_data),     64'(md));
    endtask

    initial begin
        for (int t = 0; t < 16; t++) begin
            t_valid[t] = 1'b0; t_sq[t] = 1'b0; t_addr[t] = '0; t_size[t] = '0; t_gnt[t] = '0;
        end
        wb_addr_in = '0; wr_addr_in = '0; rd_addr_in = '0; wb_data_in = '0; wr_data_in = '0;
        wr_size_in = '0; rd_size_in = '0; rd_gnt_in = '0;
        mem2proc_data = '0;

        // Reset with concurrent activity that must be ignored.
        reset = 1'b1; except = 1'b1;
        wb_en_in = 1'b1; wb_addr_in = 16'h1234; wr_en_in = 1'b1; rd_en_in = 1'b1;
        mem2proc_response = 4'd1; mem2proc_tag = 4'd3;
        @(negedge clock);
        #1;
        check_eq("rst.cmd",   64'(Dmem_command), 64'(BUS_NONE));
        check_eq("rst.ready", 64'(ready),        64'd1);
        check_eq("rst.wr_en", 64'(mem_wr_en),    64'd0);
        check_eq("rst.fb",    64'(mem_feedback), 64'd0);
        tick();
        reset = 1'b0;
        wb_en_in = 1'b0; wr_en_in = 1'b0; rd_en_in = 1'b0;
        idle("post_rst");
        check_eq("post_rst.ready", 64'(ready), 64'd1);
        tick();

        // Three enqueues in one cycle, issued in wb, wr, rd order.
        enq_wb(16'h1008, 64'hDEAD_BEEF_0000_1008);
        enq_wr(16'h2004, 64'h0000_0000_CAFE_F00D, 2'd2);
        enq_rd(16'h3006, 2'd1, 8'h04);
        idle("t1.empty");
        tick();
        accept("t1.wb", 4'd1); tick();
        accept("t1.wr", 4'd2); tick();
        accept("t1.rd", 4'd3); tick();
        complete("t1.c3", 4'd3, 64'h1122_3344_5566_7788);
        check_eq("t1.c3.lit", 64'(mem_data), 64'h0000_1122);
        tick();
        complete("t1.stale", 4'd3, 64'h1122_3344_5566_7788); tick();

        // Head held with response=0 for three cycles.
        enq_rd(16'h5010, 2'd2, 8'h01); tick();
        hold("t2.h0"); tick();
        hold("t2.h1"); tick();
        hold("t2.h2"); tick();
        accept("t2.acc", 4'd7); tick();
        complete("t2.c7", 4'd7, 64'hAABB_CCDD_EEFF_0011); tick();

        // Five loads against four MSHRs, completed out of order.
        for (int i = 0; i < 5; i++) begin
            enq_rd(16'(16'h6000 + i * 16'h0108 + i), 2'(i % 3), 8'(1 << i));
            tick();
        end
        accept("t3.a1", 4'd1); tick();
        accept("t3.a2", 4'd2); tick();
        accept("t3.a3", 4'd3); tick();
        accept("t3.a4", 4'd4); tick();
        idle("t3.stall0"); tick();
        idle("t3.stall1");
        complete("t3.c3", 4'd3, 64'h0102_0304_0506_0708); tick();
        accept("t3.a5", 4'd5);
        complete("t3.c1", 4'd1, 64'h1111_2222_3333_4444); tick();
        complete("t3.c4", 4'd4, 64'h8877_6655_4433_2211); tick();
        complete("t3.c2", 4'd2, 64'hF0E1_D2C3_B4A5_9687); tick();
        complete("t3.c5", 4'd5, 64'h0F1E_2D3C_4B5A_6978); tick();

        // Store blocked behind an outstanding load to the same block.
        enq_rd(16'h4000, 2'd3, 8'h10); tick();
        accept("t4.ld", 4'd5); tick();
        enq_wr(16'h4004, 64'h0000_0000_1234_5678, 2'd2);
        idle("t4.empty"); tick();
        idle("t4.blk0"); tick();
        idle("t4.blk1"); tick();
        idle("t4.blk2");
        complete("t4.c5", 4'd5, 64'h5555_6666_7777_8888); tick();
        accept("t4.st", 4'd9); tick();

        // Fill to the ready threshold; a further enqueue is dropped.
        enq_wb(16'h8000, 64'hA0A0_A0A0_A0A0_A0A0);
        enq_wr(16'h8108, 64'h0000_0000_0000_B1B1, 2'd1);
        enq_rd(16'h8203, 2'd0, 8'h20);
        tick();
        #1 check_eq("t5.ready3", 64'(ready), 64'd1);
        enq_wb(16'h8300, 64'hC0C0_C0C0_C0C0_C0C0);
        enq_wr(16'h8400, 64'h0000_0000_0000_00D1, 2'd0);
        enq_rd(16'h8505, 2'd1, 8'h40);
        tick();
        #1 check_eq("t5.ready6", 64'(ready), 64'd0);
        wb_en_in = 1'b1; wb_addr_in = 16'h8600; wb_data_in = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        for (int i = 1; i <= 6; i++) begin
            accept($sformatf("t5.a%0d", i), 4'(i)); tick();
        end
        idle("t5.drained");
        check_eq("t5.ready", 64'(ready), 64'd1);
        complete("t5.c6", 4'd6, 64'h0123_4567_89AB_CDEF); tick();
        complete("t5.c3", 4'd3, 64'hFEDC_BA98_7654_3210); tick();

        // Exception squashes FIFO loads and the outstanding load.
        enq_rd(16'h7008, 2'd2, 8'h80); tick();
        accept("t6.ld", 4'd6); tick();
        enq_rd(16'h7100, 2'd0, 8'h01); tick();
        enq_rd(16'h7200, 2'd1, 8'h02); tick();
        enq_rd(16'h7300, 2'd2, 8'h04);
        do_except();
        tick();
        idle("t6.sq0"); tick();
        idle("t6.sq1"); tick();
        idle("t6.sq2"); tick();
        drop_squashed();
        enq_wb(16'h7400, 64'h7777_0000_7777_0000);
        idle("t6.empty"); tick();
        accept("t6.wb", 4'd2); tick();
        complete("t6.c6", 4'd6, 64'h9999_AAAA_BBBB_CCCC); tick();
        complete("t6.stale", 4'd6, 64'h9999_AAAA_BBBB_CCCC); tick();
        idle("t6.end");
        check_eq("end.queue", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
